// File: rtl/f_fetch_buf.sv
// Fetch-to-decode instruction buffer: a circular queue of {pc, instr, exc} entries.
// Bad fetch addresses are replaced with a nop and tagged AdEL; flush empties the buffer.
module f_fetch_buf #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] PC_LO = 32'h0000_3000,
    parameter logic [31:0] PC_HI = 32'h0000_6ffc
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [31:0]                f_pc,
    input  logic [31:0]                f_instr,
    output logic                       d_valid,
    input  logic                       d_ready,
    output logic [31:0]                d_pc,
    output logic [31:0]                d_instr,
    output logic [4:0]                 d_exc_code,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic   enq, deq, fault;
    entry_t new_entry, head;

    assign f_ready = (count_q < FULL_CNT);
    assign d_valid = (count_q != '0);
    assign count   = count_q;

    assign fault = (f_pc[1:0] != 2'b00) || (f_pc < PC_LO) || (f_pc > PC_HI);

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
        new_entry = '0;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        enq = f_valid && f_ready && !flush;
        deq = d_valid && d_ready && !flush;

        new_entry.pc    = f_pc;
        new_entry.instr = fault ? 32'h0000_0000 : f_instr;
        new_entry.exc   = fault ? EXC_ADEL : 5'd0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are hidden because outputs are masked by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        d_pc       = d_valid ? head.pc    : 32'h0;
        d_instr    = d_valid ? head.instr : 32'h0;
        d_exc_code = d_valid ? head.exc   : 5'd0;
    end

endmodule

// File: tb/tb_f_fetch_buf.sv
// Self-checking bench for f_fetch_buf: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_f_fetch_buf;

    localparam int          DEPTH = 2;
    localparam logic [31:0] PC_LO = 32'h0000_3000;
    localparam logic [31:0] PC_HI = 32'h0000_6ffc;
    localparam int          CNT_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              f_valid = 1'b0;
    logic              f_ready;
    logic [31:0]       f_pc = '0;
    logic [31:0]       f_instr = '0;
    logic              d_valid;
    logic              d_ready = 1'b0;
    logic [31:0]       d_pc;
    logic [31:0]       d_instr;
    logic [4:0]        d_exc_code;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    f_fetch_buf #(.DEPTH(DEPTH), .PC_LO(PC_LO), .PC_HI(PC_HI)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .f_valid    (f_valid),
        .f_ready    (f_ready),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_exc_code (d_exc_code),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } m_entry_t;

    m_entry_t model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of entries, updated once per rising edge.
    always @(posedge clk) begin
        bit       had_room, had_head;
        m_entry_t e;
        had_room = (model_q.size() < DEPTH);
        had_head = (model_q.size() != 0);
        if (reset || flush) begin
            model_q.delete();
        end else begin
            if (had_head && d_ready) void'(model_q.pop_front());
            if (f_valid && had_room) begin
                e.pc = f_pc;
                if (f_pc[1:0] != 2'b00 || f_pc < PC_LO || f_pc > PC_HI) begin
                    e.instr = 32'h0;
                    e.exc   = 5'd4;
                end else begin
                    e.instr = f_instr;
                    e.exc   = 5'd0;
                end
                model_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count",   32'(count),   32'(model_q.size()));
            check("m_f_ready", 32'(f_ready), 32'(model_q.size() < DEPTH));
            check("m_d_valid", 32'(d_valid), 32'(model_q.size() != 0));
            if (model_q.size() == 0) begin
                check("m_d_pc",    d_pc,            32'h0);
                check("m_d_instr", d_instr,         32'h0);
                check("m_d_exc",   32'(d_exc_code), 32'h0);
            end else begin
                check("m_d_pc",    d_pc,            model_q[0].pc);
                check("m_d_instr", d_instr,         model_q[0].instr);
                check("m_d_exc",   32'(d_exc_code), 32'(model_q[0].exc));
            end
        end
    end

    // Drive one cycle of inputs, advance one edge, and settle just after it.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic dr, input logic fl, input logic rs);
        f_valid = v;
        f_pc    = pc;
        f_instr = instr;
        d_ready = dr;
        flush   = fl;
        reset   = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 1);
        check("rst_count",   32'(count),      32'd0);
        check("rst_f_ready", 32'(f_ready),    32'd1);
        check("rst_d_valid", 32'(d_valid),    32'd0);
        check("rst_d_pc",    d_pc,            32'h0);
        check("rst_d_instr", d_instr,         32'h0);
        check("rst_d_exc",   32'(d_exc_code), 32'h0);

        // Streaming with D always ready.
        cyc(1, 32'h3000, 32'h1111_0000, 1, 0, 0);
        check("str_pc0", d_pc, 32'h3000);
        check("str_cnt0", 32'(count), 32'd1);
        cyc(1, 32'h3004, 32'h1111_0004, 1, 0, 0);
        check("str_pc1", d_pc, 32'h3004);
        cyc(1, 32'h3008, 32'h1111_0008, 1, 0, 0);
        check("str_pc2", d_pc, 32'h3008);
        check("str_cnt2", 32'(count), 32'd1);
        drain();

        // Stall fill: third push must be refused.
        cyc(1, 32'h3000, 32'h2222_0000, 0, 0, 0);
        cyc(1, 32'h3004, 32'h2222_0004, 0, 0, 0);
        check("stall_cnt", 32'(count), 32'd2);
        check("stall_f_ready", 32'(f_ready), 32'd0);
        cyc(1, 32'h3008, 32'h2222_0008, 0, 0, 0);
        check("stall_cnt_hold", 32'(count), 32'd2);
        check("stall_head", d_pc, 32'h3000);
        cyc(0, 0, 0, 1, 0, 0);
        check("rel_head", d_pc, 32'h3004);
        check("rel_f_ready", 32'(f_ready), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        check("rel_empty", 32'(d_valid), 32'd0);

        // Simultaneous enqueue/dequeue at count=1 across pointer wrap.
        cyc(1, 32'h3000, 32'h3333_0000, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 32'h300c + 32'(4 * k), 32'h3333_0010 + 32'(k), 1, 0, 0);
            check("sim_head", d_pc, 32'h300c + 32'(4 * k));
            check("sim_instr", d_instr, 32'h3333_0010 + 32'(k));
            check("sim_cnt", 32'(count), 32'd1);
        end
        drain();

        // Address faults and the inclusive upper bound.
        cyc(1, 32'h3002, 32'h2408_0001, 1, 0, 0);
        check("flt_mis_exc", 32'(d_exc_code), 32'd4);
        check("flt_mis_instr", d_instr, 32'h0);
        check("flt_mis_pc", d_pc, 32'h3002);
        cyc(1, 32'h2ffc, 32'h2408_0001, 1, 0, 0);
        check("flt_lo_exc", 32'(d_exc_code), 32'd4);
        check("flt_lo_pc", d_pc, 32'h2ffc);
        cyc(1, 32'h7000, 32'h2408_0001, 1, 0, 0);
        check("flt_hi_exc", 32'(d_exc_code), 32'd4);
        check("flt_hi_instr", d_instr, 32'h0);
        cyc(1, 32'h6ffc, 32'h2408_0001, 1, 0, 0);
        check("ok_hi_exc", 32'(d_exc_code), 32'd0);
        check("ok_hi_instr", d_instr, 32'h2408_0001);
        drain();

        // Flush drops contents and the same-cycle push.
        cyc(1, 32'h3000, 32'h4444_0000, 0, 0, 0);
        cyc(1, 32'h3004, 32'h4444_0004, 0, 0, 0);
        cyc(1, 32'h3010, 32'h4444_0010, 1, 1, 0);
        check("fl_cnt", 32'(count), 32'd0);
        check("fl_d_valid", 32'(d_valid), 32'd0);
        check("fl_d_instr", d_instr, 32'h0);
        cyc(1, 32'h3020, 32'h4444_0020, 0, 0, 0);
        check("fl_first", d_pc, 32'h3020);
        check("fl_first_instr", d_instr, 32'h4444_0020);
        drain();

        // Reset mid-stream.
        cyc(1, 32'h3000, 32'h5555_0000, 0, 0, 0);
        cyc(1, 32'h3004, 32'h5555_0004, 0, 0, 0);
        cyc(1, 32'h3030, 32'h5555_0030, 0, 1, 1);
        check("mrst_cnt", 32'(count), 32'd0);
        check("mrst_f_ready", 32'(f_ready), 32'd1);
        check("mrst_d_pc", d_pc, 32'h0);
        check("mrst_d_instr", d_instr, 32'h0);
        check("mrst_d_exc", 32'(d_exc_code), 32'h0);

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 48; i++) begin
            cyc((i % 4) != 3, 32'h2ff8 + 32'(i * 6), 32'hA000_0000 + 32'(i),
                (i % 3) != 0, (i == 29), 1'b0);
        end
        drain();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
